// File: rtl/wb_chan_regbank.sv
// Wishbone register bank with N_CHAN channels, each a byte-lane writable CTRL
// register and a sticky write-1-to-clear STAT register; selectable read/write stages.
module wb_chan_regbank #(
    parameter int              N_CHAN   = 4,
    parameter int              F_W      = 8,
    parameter int              AW       = 6,
    parameter logic [F_W-1:0]  CTRL_RST = '0,
    parameter int              RD_PIPE  = 1,
    parameter int              WR_PIPE  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [AW-3:0]           wb_adr_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [31:0]             wb_dat_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    output logic                    wb_stall_o,
    output logic [31:0]             wb_dat_o,
    output logic [N_CHAN*F_W-1:0]   ctrl_o,
    output logic [N_CHAN-1:0]       ctrl_wr_o,
    input  logic [N_CHAN*F_W-1:0]   stat_i
);

    localparam int WA_W = AW - 2;

    logic [F_W-1:0]       ctrl_q [N_CHAN];
    logic [F_W-1:0]       stat_q [N_CHAN];
    logic                 busy;
    logic                 accept;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [2*N_CHAN-1:0]  rd_hit;
    logic [2*N_CHAN-1:0]  wr_hit;
    logic                 rd_mapped;
    logic                 wr_mapped;
    logic [31:0]          rdata;
    logic                 wr_vld;
    logic [WA_W-1:0]      wr_adr;
    logic [31:0]          wr_dat;
    logic [3:0]           wr_sel;
    logic [F_W-1:0]       wmask;
    logic                 rd_ack;
    logic                 rd_err;
    logic [31:0]          rd_dat;
    logic                 wr_ack_q;
    logic                 wr_err_q;
    logic [N_CHAN-1:0]    ctrl_wr_q;
    logic                 unused_wr;

    // Byte lane k covers bits [8k+7:8k]; bits above F_W simply do not exist.
    function automatic logic [F_W-1:0] lane_mask(input logic [3:0] sel);
        logic [F_W-1:0] m;
        for (int i = 0; i < F_W; i++) begin
            m[i] = sel[i/8];
        end
        return m;
    endfunction

    // Bit 2c flags CTRL[c], bit 2c+1 flags STAT[c]; no bit set means unmapped.
    function automatic logic [2*N_CHAN-1:0] decode(input logic [WA_W-1:0] wa);
        logic [2*N_CHAN-1:0] hit;
        for (int w = 0; w < 2*N_CHAN; w++) begin
            hit[w] = (wa == WA_W'(w));
        end
        return hit;
    endfunction

    assign accept    = wb_cyc_i & wb_stb_i & ~busy;
    assign rd_acc    = accept & ~wb_we_i;
    assign wr_acc    = accept & wb_we_i;
    assign rd_hit    = decode(wb_adr_i);
    assign rd_mapped = |rd_hit;
    assign wr_hit    = decode(wr_adr);
    assign wr_mapped = |wr_hit;
    assign wmask     = lane_mask(wr_sel);
    assign unused_wr = ^{wr_dat, wr_sel};

    always_comb begin
        rdata = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (rd_hit[2*c])   rdata[F_W-1:0] = rdata[F_W-1:0] | ctrl_q[c];
            if (rd_hit[2*c+1]) rdata[F_W-1:0] = rdata[F_W-1:0] | stat_q[c];
        end
    end

    // Write stage p0: optional capture of the accepted write before commit.
    generate
        if (WR_PIPE != 0) begin : g_wr_pipe
            logic            vld_p0;
            logic [WA_W-1:0] adr_p0;
            logic [31:0]     dat_p0;
            logic [3:0]      sel_p0;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    vld_p0 <= 1'b0;
                end else begin
                    vld_p0 <= wr_acc;
                end
            end

            always_ff @(posedge clk_i) begin
                if (wr_acc) begin
                    adr_p0 <= wb_adr_i;
                    dat_p0 <= wb_dat_i;
                    sel_p0 <= wb_sel_i;
                end
            end

            assign wr_vld = vld_p0;
            assign wr_adr = adr_p0;
            assign wr_dat = dat_p0;
            assign wr_sel = sel_p0;
        end else begin : g_wr_direct
            assign wr_vld = wr_acc;
            assign wr_adr = wb_adr_i;
            assign wr_dat = wb_dat_i;
            assign wr_sel = wb_sel_i;
        end
    endgenerate

    // Commit stage: registers update; a status event in the same cycle beats a clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < N_CHAN; c++) begin
                ctrl_q[c] <= CTRL_RST;
                stat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (wr_vld && wr_hit[2*c]) begin
                    ctrl_q[c] <= (ctrl_q[c] & ~wmask) | (wr_dat[F_W-1:0] & wmask);
                end
                stat_q[c] <= (stat_q[c] & ~((wr_vld && wr_hit[2*c+1]) ?
                                             (wr_dat[F_W-1:0] & wmask) : '0))
                           | stat_i[c*F_W +: F_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy      <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            ctrl_wr_q <= '0;
        end else begin
            // Combinational reads complete in the accept cycle and never occupy the bank.
            busy      <= busy ? ~(wb_ack_o | wb_err_o)
                              : (accept & (wb_we_i | (RD_PIPE != 0)));
            wr_ack_q  <= wr_vld & wr_mapped;
            wr_err_q  <= wr_vld & ~wr_mapped;
            for (int c = 0; c < N_CHAN; c++) begin
                ctrl_wr_q[c] <= wr_vld & wr_hit[2*c];
            end
        end
    end

    // Read stage p0: optional registering of read response.
    generate
        if (RD_PIPE != 0) begin : g_rd_reg
            logic        ack_p0;
            logic        err_p0;
            logic [31:0] dat_p0;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    ack_p0 <= 1'b0;
                    err_p0 <= 1'b0;
                    dat_p0 <= '0;
                end else begin
                    ack_p0 <= rd_acc & rd_mapped;
                    err_p0 <= rd_acc & ~rd_mapped;
                    dat_p0 <= (rd_acc & rd_mapped) ? rdata : '0;
                end
            end

            assign rd_ack = ack_p0;
            assign rd_err = err_p0;
            assign rd_dat = dat_p0;
        end else begin : g_rd_comb
            assign rd_ack = rd_acc & rd_mapped;
            assign rd_err = rd_acc & ~rd_mapped;
            assign rd_dat = (rd_acc & rd_mapped) ? rdata : '0;
        end
    endgenerate

    generate
        for (genvar c = 0; c < N_CHAN; c++) begin : g_ctrl_out
            assign ctrl_o[c*F_W +: F_W] = ctrl_q[c];
        end
    endgenerate

    assign wb_ack_o   = rd_ack | wr_ack_q;
    assign wb_err_o   = rd_err | wr_err_q;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
    assign wb_dat_o   = rd_dat;
    assign ctrl_wr_o  = ctrl_wr_q;

endmodule
